mem_stage: RTL and testbench

Memory-access stage of the five-stage LoongArch pipeline. It sits directly downstream of the EXE→MEM pipeline register and upstream of the MEM→WB register. It issues load/store transactions on an SRAM-like request/response data bus and builds byte strobes for stores. It also extracts and extends load data and stalls the pipeline until the response returns. Outstanding transactions are cancelled cleanly on a writeback exception or ertn flush.

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_load_align.sv | 39 +++
 rtl/mem_stage.sv | 199 +++++++++++++++++++
 tb/tb_mem_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage and its helpers.
//   - access size encodings used on the data bus and by load alignment
//   - FSM state encoding for mem_stage
package mem_stage_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_HOLD   = 3'd3,
      ST_CANCEL = 3'd4
   } mem_state_t;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extraction: picks the addressed byte/half out of a
// 32-bit read word and sign- or zero-extends it. Word loads pass unchanged.
// Shared with the cache refill path, so it carries no state.
// Ports:
//   i_rdata    32  raw read word
//   i_addr_lo  2   low address bits selecting the lane
//   i_size     2   SZ_BYTE / SZ_HALF / SZ_WORD
//   i_sext     1   sign-extend request
//   i_zext     1   zero-extend request (wins over i_sext if both set)
//   o_data     32  extracted, extended value
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_sext,
   input  logic        i_zext,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sign;

   assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
   assign w_sign = i_sext & ~i_zext;

   always_comb begin
      o_data = i_rdata;
      case (i_size)
         SZ_BYTE: o_data = {{24{w_sign & w_byte[7]}}, w_byte};
         SZ_HALF: o_data = {{16{w_sign & w_half[15]}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on an SRAM-like req/resp bus,
// builds store strobes and lane-replicated data, extracts load data and
// stalls until the response returns. WB flushes cancel outstanding
// transactions without losing bus protocol sync.
// Optional build macro: MEM_STAGE_ALE_CHECK_EN enables in-stage alignment
// checking (misaligned access -> out_ex_ale, no bus request).
// Ports:
//   clk, rst (sync, active-high); wb_ex / wb_is_ertn flush
//   in_*          EXE->MEM register contents
//   wb_allowin    MEM->WB register can accept
//   mem_ready_go / mem_allowin   pipeline handshake
//   data_*        request/response data bus
//   out_*         result to MEM->WB register
//
// state  | meaning
// IDLE   | no transaction; request driven straight from inputs
// REQ    | request raised, waiting for addr_ok (latched fields)
// WAIT   | request accepted, waiting for data_ok
// HOLD   | response captured, waiting for wb_allowin
// CANCEL | flushed after acceptance; swallow one data_ok
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_ex,
   input  logic        wb_is_ertn,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_addr,
   input  logic        in_dram_re,
   input  logic        in_dram_we,
   input  logic [31:0] in_wdata,
   input  logic [1:0]  in_rdram_num,
   input  logic [1:0]  in_wdram_num,
   input  logic        in_sext,
   input  logic        in_zext,
   input  logic        in_has_ex,
   input  logic        wb_allowin,
   output logic        mem_ready_go,
   output logic        mem_allowin,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_ok,
   input  logic [31:0] data_rdata,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_load_data,
   output logic        out_ex_ale
);

   mem_state_t  r_state, w_next;
   logic        r_cancel;
   logic [31:0] r_addr, r_wdata, r_load_data;
   logic [1:0]  r_size;
   logic [3:0]  r_strb;
   logic        r_wr;

   logic        w_flush, w_mem_op, w_ale, w_access, w_idle_req;
   logic [1:0]  w_size;
   logic [3:0]  w_strb;
   logic [31:0] w_wdata, w_ext;

   assign w_flush  = wb_ex | wb_is_ertn;
   assign w_mem_op = in_valid & (in_dram_re | in_dram_we) & ~in_has_ex;
   assign w_size   = in_dram_we ? in_wdram_num : in_rdram_num;

`ifdef MEM_STAGE_ALE_CHECK_EN
   assign w_ale = w_mem_op & (((w_size == SZ_HALF) & in_addr[0]) |
                              ((w_size == SZ_WORD) & (in_addr[1:0] != 2'b00)));
`else
   assign w_ale = 1'b0;
`endif

   assign w_access = w_mem_op & ~w_ale;
   // A request is never raised in a flush cycle, so IDLE can drop the
   // instruction immediately without owing the bus a response.
   assign w_idle_req = (r_state == ST_IDLE) & w_access & ~w_flush;

   always_comb begin
      w_strb  = 4'b1111;
      w_wdata = in_wdata;
      case (w_size)
         SZ_BYTE: begin
            w_strb  = 4'b0001 << in_addr[1:0];
            w_wdata = {4{in_wdata[7:0]}};
         end
         SZ_HALF: begin
            w_strb  = 4'b0011 << {in_addr[1], 1'b0};
            w_wdata = {2{in_wdata[15:0]}};
         end
         default: begin
            w_strb  = 4'b1111;
            w_wdata = in_wdata;
         end
      endcase
      w_strb = w_strb & {4{in_dram_we}};
   end

   mem_load_align u_align (
      .i_rdata   (data_rdata),
      .i_addr_lo (in_addr[1:0]),
      .i_size    (in_rdram_num),
      .i_sext    (in_sext),
      .i_zext    (in_zext),
      .o_data    (w_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cancel    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_size      <= '0;
         r_strb      <= '0;
         r_wr        <= 1'b0;
         r_load_data <= '0;
      end else begin
         r_state  <= w_next;
         // Remembers a flush seen while the request is still unaccepted.
         r_cancel <= (r_state == ST_REQ) & ~data_addr_ok & (r_cancel | w_flush);
         if (w_idle_req) begin
            r_addr  <= in_addr;
            r_wdata <= w_wdata;
            r_size  <= w_size;
            r_strb  <= w_strb;
            r_wr    <= in_dram_we;
         end
         if ((r_state == ST_WAIT) & data_ok & ~w_flush)
            r_load_data <= w_ext;
      end
   end

   always_comb begin
      w_next        = r_state;
      data_req      = 1'b0;
      data_wr       = 1'b0;
      data_size     = '0;
      data_addr     = '0;
      data_wstrb    = '0;
      data_wdata    = '0;
      mem_ready_go  = 1'b0;
      out_load_data = r_load_data;
      case (r_state)
         ST_IDLE: begin
            mem_ready_go = in_valid & ~w_access;
            if (w_idle_req) begin
               data_req   = 1'b1;
               data_wr    = in_dram_we;
               data_size  = w_size;
               data_addr  = in_addr;
               data_wstrb = w_strb;
               data_wdata = w_wdata;
               w_next     = data_addr_ok ? ST_WAIT : ST_REQ;
            end
         end
         ST_REQ: begin
            data_req   = 1'b1;
            data_wr    = r_wr;
            data_size  = r_size;
            data_addr  = r_addr;
            data_wstrb = r_strb;
            data_wdata = r_wdata;
            if (data_addr_ok)
               w_next = (r_cancel | w_flush) ? ST_CANCEL : ST_WAIT;
         end
         ST_WAIT: begin
            out_load_data = w_ext;
            mem_ready_go  = data_ok & ~w_flush;
            if (w_flush)
               w_next = data_ok ? ST_IDLE : ST_CANCEL;
            else if (data_ok)
               w_next = wb_allowin ? ST_IDLE : ST_HOLD;
         end
         ST_HOLD: begin
            mem_ready_go = 1'b1;
            if (w_flush | wb_allowin)
               w_next = ST_IDLE;
         end
         ST_CANCEL: begin
            if (data_ok)
               w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign mem_allowin = ~in_valid | (mem_ready_go & wb_allowin);
   assign out_valid   = in_valid & mem_ready_go & ~w_flush;
   assign out_pc      = in_pc;
   assign out_ex_ale  = (r_state == ST_IDLE) & w_ale;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst, wb_ex, wb_is_ertn, in_valid;
   logic [31:0] in_pc, in_addr, in_wdata;
   logic        in_dram_re, in_dram_we, in_sext, in_zext, in_has_ex, wb_allowin;
   logic [1:0]  in_rdram_num, in_wdram_num;
   logic        mem_ready_go, mem_allowin, data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_ok;
   logic        out_valid, out_ex_ale;
   logic [31:0] out_pc, out_load_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst(rst), .wb_ex(wb_ex), .wb_is_ertn(wb_is_ertn),
      .in_valid(in_valid), .in_pc(in_pc), .in_addr(in_addr),
      .in_dram_re(in_dram_re), .in_dram_we(in_dram_we), .in_wdata(in_wdata),
      .in_rdram_num(in_rdram_num), .in_wdram_num(in_wdram_num),
      .in_sext(in_sext), .in_zext(in_zext), .in_has_ex(in_has_ex),
      .wb_allowin(wb_allowin), .mem_ready_go(mem_ready_go), .mem_allowin(mem_allowin),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_ok(data_ok), .data_rdata(data_rdata),
      .out_valid(out_valid), .out_pc(out_pc), .out_load_data(out_load_data),
      .out_ex_ale(out_ex_ale)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: lane-level view of the bus, independent of RTL encoding.
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] exp_strb(input logic [1:0] sz, input logic [31:0] addr);
      int n = nbytes(sz);
      int start = int'(addr[1:0]) - (int'(addr[1:0]) % n);
      logic [31:0] s = 0;
      for (int i = 0; i < 4; i++)
         if (i >= start && i < start + n) s = s | (32'd1 << i);
      return s;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
      int n = nbytes(sz);
      logic [31:0] r = 0;
      for (int i = 0; i < 4; i++)
         r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
      return r;
   endfunction

   function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic [31:0] addr,
                                            input logic [31:0] rd, input bit sx, input bit zx);
      int n = nbytes(sz);
      int start = int'(addr[1:0]) - (int'(addr[1:0]) % n);
      logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
      logic [31:0] v = (rd >> (8 * start)) & mask;
      if (n < 4 && sx && !zx && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic set_op(input bit we, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input bit sx, input bit zx);
      in_valid = 1'b1; in_pc = $urandom; in_addr = addr;
      in_dram_re = !we; in_dram_we = we; in_wdata = wd;
      in_rdram_num = sz; in_wdram_num = sz; in_sext = sx; in_zext = zx; in_has_ex = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic run_mem(input bit we, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input bit sx,
                          input bit zx, input int ado, input int dok, input int hold);
      logic [31:0] eload, epc;
      eload = exp_load(sz, addr, rd, sx, zx);
      set_op(we, sz, addr, wd, sx, zx);
      epc = in_pc;
      wb_allowin = 1'b1; data_ok = 1'b0;
      for (int c = 0; c <= ado; c++) begin
         data_addr_ok = (c == ado);
         #4;
         chk("req", 32'(data_req), 32'd1);
         chk("addr", data_addr, addr);
         chk("wr", 32'(data_wr), 32'(we));
         chk("size", 32'(data_size), 32'(sz));
         if (we) begin
            chk("wstrb", 32'(data_wstrb), exp_strb(sz, addr));
            chk("wdata", data_wdata, exp_wdata(sz, wd));
         end
         chk("rdy_req", 32'(mem_ready_go), 32'd0);
         chk("allowin_req", 32'(mem_allowin), 32'd0);
         chk("ale_req", 32'(out_ex_ale), 32'd0);
         step();
      end
      data_addr_ok = 1'b0;
      for (int c = 0; c <= dok; c++) begin
         data_ok = (c == dok);
         data_rdata = (c == dok) ? rd : $urandom;
         wb_allowin = (c == dok) ? (hold == 0) : 1'b1;
         #4;
         if (c < dok) begin
            chk("rdy_wait", 32'(mem_ready_go), 32'd0);
            chk("req_wait", 32'(data_req), 32'd0);
            chk("oval_wait", 32'(out_valid), 32'd0);
         end else begin
            chk("rdy_ok", 32'(mem_ready_go), 32'd1);
            chk("oval_ok", 32'(out_valid), 32'd1);
            chk("allowin_ok", 32'(mem_allowin), 32'(hold == 0));
            chk("pc_ok", out_pc, epc);
            if (!we) chk("load_ok", out_load_data, eload);
         end
         step();
      end
      data_ok = 1'b0; data_rdata = $urandom;
      for (int h = 1; h <= hold; h++) begin
         wb_allowin = (h == hold);
         #4;
         chk("rdy_hold", 32'(mem_ready_go), 32'd1);
         chk("allowin_hold", 32'(mem_allowin), 32'(h == hold));
         chk("req_hold", 32'(data_req), 32'd0);
         if (!we) chk("load_hold", out_load_data, eload);
         step();
      end
      in_valid = 1'b0; in_dram_re = 1'b0; in_dram_we = 1'b0; wb_allowin = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; wb_ex = 1'b0; wb_is_ertn = 1'b0; in_valid = 1'b0; in_pc = 0; in_addr = 0;
      in_wdata = 0; in_dram_re = 0; in_dram_we = 0; in_sext = 0; in_zext = 0; in_has_ex = 0;
      in_rdram_num = 0; in_wdram_num = 0; wb_allowin = 1'b1;
      data_addr_ok = 0; data_ok = 0; data_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(data_req), 32'd0);
      chk("rst_allowin", 32'(mem_allowin), 32'd1);
      chk("rst_rdy", 32'(mem_ready_go), 32'd0);
      chk("rst_oval", 32'(out_valid), 32'd0);
      chk("rst_load", out_load_data, 32'd0);
      chk("rst_addr", data_addr, 32'd0);
      rst = 1'b0;
      step();

      // Word load, minimum latency.
      run_mem(0, 2'd2, 32'h1000, 0, 32'h89AB_CDEF, 0, 0, 0, 0, 0);
      // Signed and zero-extended byte loads from lane 3.
      run_mem(0, 2'd0, 32'h1003, 0, 32'h80FF_FFFF, 1, 0, 0, 0, 0);
      run_mem(0, 2'd0, 32'h1003, 0, 32'h80FF_FFFF, 0, 1, 0, 0, 0);
      // Half store at upper half.
      run_mem(1, 2'd1, 32'h2002, 32'h0000_1234, 0, 0, 0, 0, 0, 0);
      // Response with wb_allowin low for two cycles.
      run_mem(0, 2'd1, 32'h5002, 0, 32'h8001_7F00, 1, 0, 1, 2, 2);

      // Non-memory pass-through and earlier-exception pass-through.
      set_op(0, 2'd2, 32'h6000, 0, 0, 0);
      in_dram_re = 1'b0; in_pc = 32'h1234_5678;
      #4;
      chk("nm_rdy", 32'(mem_ready_go), 32'd1);
      chk("nm_oval", 32'(out_valid), 32'd1);
      chk("nm_req", 32'(data_req), 32'd0);
      chk("nm_pc", out_pc, 32'h1234_5678);
      step();
      set_op(0, 2'd2, 32'h6000, 0, 0, 0);
      in_has_ex = 1'b1;
      #4;
      chk("hx_rdy", 32'(mem_ready_go), 32'd1);
      chk("hx_req", 32'(data_req), 32'd0);
      step();
      in_has_ex = 1'b0; in_valid = 1'b0;

      // Flush during REQ: request held with latched fields, one data_ok swallowed.
      set_op(0, 2'd2, 32'h3000, 0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         wb_ex = (c == 1);
         data_addr_ok = (c == 3);
         if (c >= 2) begin in_valid = 1'b0; in_dram_re = 1'b0; in_addr = 32'hDEAD_0000; end
         #4;
         chk("fl_req", 32'(data_req), 32'd1);
         chk("fl_addr", data_addr, 32'h3000);
         chk("fl_oval", 32'(out_valid), 32'd0);
         step();
      end
      wb_ex = 1'b0; data_addr_ok = 1'b0;
      set_op(0, 2'd2, 32'h4000, 0, 0, 0);
      for (int c = 0; c < 2; c++) begin
         data_ok = (c == 1); data_rdata = $urandom;
         #4;
         chk("cn_req", 32'(data_req), 32'd0);
         chk("cn_rdy", 32'(mem_ready_go), 32'd0);
         chk("cn_oval", 32'(out_valid), 32'd0);
         step();
      end
      data_ok = 1'b0;
      run_mem(0, 2'd2, 32'h4000, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0);

      // Flush and data_ok together in WAIT: straight back to IDLE.
      set_op(0, 2'd2, 32'h7000, 0, 0, 0);
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0; wb_is_ertn = 1'b1; data_ok = 1'b1;
      #4;
      chk("wf_rdy", 32'(mem_ready_go), 32'd0);
      chk("wf_oval", 32'(out_valid), 32'd0);
      step();
      wb_is_ertn = 1'b0; data_ok = 1'b0;
      run_mem(0, 2'd0, 32'h7001, 0, 32'h0000_A500, 0, 0, 0, 0, 0);

      // Flush in WAIT without response: CANCEL swallows the late data_ok.
      set_op(0, 2'd2, 32'h7100, 0, 0, 0);
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0; wb_ex = 1'b1;
      #4;
      chk("wc_oval", 32'(out_valid), 32'd0);
      step();
      wb_ex = 1'b0; data_ok = 1'b1;
      #4;
      chk("wc_req", 32'(data_req), 32'd0);
      chk("wc_oval2", 32'(out_valid), 32'd0);
      step();
      data_ok = 1'b0;
      run_mem(1, 2'd0, 32'h7103, 32'h0000_00C3, 0, 0, 0, 0, 1, 0);

      // Reset mid-transaction.
      set_op(0, 2'd2, 32'h7200, 0, 0, 0);
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0; in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      run_mem(0, 2'd2, 32'h7204, 0, 32'h1357_9BDF, 0, 0, 0, 0, 0);

      // Misaligned word load.
`ifdef MEM_STAGE_ALE_CHECK_EN
      set_op(0, 2'd2, 32'h1002, 0, 0, 0);
      #4;
      chk("ale_flag", 32'(out_ex_ale), 32'd1);
      chk("ale_req", 32'(data_req), 32'd0);
      chk("ale_rdy", 32'(mem_ready_go), 32'd1);
      step();
      in_valid = 1'b0;
`else
      run_mem(0, 2'd2, 32'h1002, 0, 32'h2468_ACE0, 0, 0, 0, 0, 0);
`endif

      // Randomized aligned traffic.
      for (int t = 0; t < 40; t++) begin
         logic [1:0]  sz;
         logic [31:0] addr;
         bit          we, sx;
         sz = 2'($urandom_range(0, 2));
         addr = $urandom;
         if (sz == 2'd1) addr[0] = 1'b0;
         if (sz == 2'd2) addr[1:0] = 2'b00;
         we = 1'($urandom_range(0, 1));
         sx = 1'($urandom_range(0, 1));
         run_mem(we, sz, addr, $urandom, $urandom, sx, !sx,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
